// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared IF-stage defaults, state encoding and IF/ID record (IF_ALIGN_CHECK_EN adds AdEL)
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h004000a8;
    localparam logic [31:0] NOP_INST_DEF = 32'h00000000;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_DROP = 2'd1,
        IF_HOLD = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_add_four;
        logic        valid;
`ifdef IF_ALIGN_CHECK_EN
        logic        adel;
`endif
    } ifid_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_ifid_reg.sv
// rtl/pipe_ifid_reg.sv - IF/ID pipeline register with flush > load > stall priority
module pipe_ifid_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  stall,
    input  logic  load,
    input  ifid_t load_rec,
    output ifid_t rec
);

    // A bubble keeps pc_add_four so a flushed slot still reports its last fetch+4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec      <= '0;
            rec.inst <= NOP_INST;
        end else if (flush || (!load && !stall)) begin
            rec.inst  <= NOP_INST;
            rec.valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            rec.adel  <= 1'b0;
`endif
        end else if (load) begin
            rec <= load_rec;
        end
    end

endmodule

// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - instruction fetch FSM, PC and IF/ID register (IF_ALIGN_CHECK_EN adds oIFID_AdEL)
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iStall,
    input  logic        iFlush,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    input  logic        _iPCLoad,
    input  logic [31:0] _iPCLoadData,
    output logic        oInstReq,
    output logic [31:0] oRdInstAddr,
    input  logic        iInstAck,
    input  logic [31:0] iRdInst,
    output logic [31:0] oIFID_Inst,
    output logic [31:0] oIFID_PCAddFour,
    output logic        oIFID_Valid,
`ifdef IF_ALIGN_CHECK_EN
    output logic        oIFID_AdEL,
`endif
    output logic [31:0] _oPC,
    output logic [31:0] _oPCNext
);

    if_state_t   state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] req_addr;
    logic [31:0] hold_buf;
    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        pc_inc;
    ifid_t       cap_rec;
    ifid_t       ifid;

    assign redirect   = _iPCLoad | iRedirect;
    assign target_raw = _iPCLoad ? _iPCLoadData : iRedirectPC;

`ifdef IF_ALIGN_CHECK_EN
    logic target_mis;
    logic pc_adel;
    assign target     = {target_raw[31:2], 2'b00};
    assign target_mis = |target_raw[1:0];
`else
    assign target = target_raw;
`endif

    // PC advances by 4 exactly when a word is handed to IF/ID, so this doubles as the capture strobe.
    always_comb begin
        pc_inc = 1'b0;
        case (state)
            IF_REQ:  pc_inc = iInstAck && !redirect && !iStall;
            IF_HOLD: pc_inc = !redirect && !iStall;
            default: pc_inc = 1'b0;
        endcase
    end

    assign pc_next = redirect ? target : (pc_inc ? pc_plus4(pc) : pc);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= IF_REQ;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            hold_buf <= '0;
`ifdef IF_ALIGN_CHECK_EN
            pc_adel  <= 1'b0;
`endif
        end else begin
            pc <= pc_next;
`ifdef IF_ALIGN_CHECK_EN
            if (redirect)
                pc_adel <= target_mis;
            else if (pc_inc)
                pc_adel <= 1'b0;
`endif
            case (state)
                IF_REQ: begin
                    if (iInstAck) begin
                        if (redirect || !iStall) begin
                            req_addr <= pc_next;
                        end else begin
                            hold_buf <= iRdInst;
                            state    <= IF_HOLD;
                        end
                    end else if (redirect) begin
                        state <= IF_DROP;
                    end
                end
                // Old request is still in flight; its data is thrown away on arrival.
                IF_DROP: begin
                    if (iInstAck) begin
                        req_addr <= pc_next;
                        state    <= IF_REQ;
                    end
                end
                IF_HOLD: begin
                    if (redirect || !iStall) begin
                        req_addr <= pc_next;
                        state    <= IF_REQ;
                    end
                end
                default: state <= IF_REQ;
            endcase
        end
    end

    always_comb begin
        cap_rec             = '0;
        cap_rec.inst        = (state == IF_HOLD) ? hold_buf : iRdInst;
        cap_rec.pc_add_four = pc_plus4(pc);
        cap_rec.valid       = 1'b1;
`ifdef IF_ALIGN_CHECK_EN
        cap_rec.adel        = pc_adel;
`endif
    end

    pipe_ifid_reg #(
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk      (iClk),
        .rst_n    (iRst_n),
        .flush    (iFlush),
        .stall    (iStall),
        .load     (pc_inc),
        .load_rec (cap_rec),
        .rec      (ifid)
    );

    assign oInstReq        = (state != IF_HOLD);
    assign oRdInstAddr     = req_addr;
    assign oIFID_Inst      = ifid.inst;
    assign oIFID_PCAddFour = ifid.pc_add_four;
    assign oIFID_Valid     = ifid.valid;
`ifdef IF_ALIGN_CHECK_EN
    assign oIFID_AdEL      = ifid.adel;
`endif
    assign _oPC            = pc;
    assign _oPCNext        = pc_next;

endmodule

// File: tb/tb_pipe_if_stage.sv
// tb/tb_pipe_if_stage.sv - scoreboard bench for pipe_if_stage (IF_ALIGN_CHECK_EN aware)
module tb_pipe_if_stage;

    localparam logic [31:0] RST_PC = 32'h004000a8;
    localparam logic [31:0] NOP    = 32'h00000000;

    logic        clk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iStall = 1'b0, iFlush = 1'b0, iRedirect = 1'b0, _iPCLoad = 1'b0, iInstAck = 1'b0;
    logic [31:0] iRedirectPC = '0, _iPCLoadData = '0, iRdInst = '0;
    logic        oInstReq, oIFID_Valid;
    logic [31:0] oRdInstAddr, oIFID_Inst, oIFID_PCAddFour, _oPC, _oPCNext;
`ifdef IF_ALIGN_CHECK_EN
    logic        oIFID_AdEL;
`endif

    always #5 clk = ~clk;

    pipe_if_stage dut (
        .iClk            (clk),
        .iRst_n          (iRst_n),
        .iStall          (iStall),
        .iFlush          (iFlush),
        .iRedirect       (iRedirect),
        .iRedirectPC     (iRedirectPC),
        ._iPCLoad        (_iPCLoad),
        ._iPCLoadData    (_iPCLoadData),
        .oInstReq        (oInstReq),
        .oRdInstAddr     (oRdInstAddr),
        .iInstAck        (iInstAck),
        .iRdInst         (iRdInst),
        .oIFID_Inst      (oIFID_Inst),
        .oIFID_PCAddFour (oIFID_PCAddFour),
        .oIFID_Valid     (oIFID_Valid),
`ifdef IF_ALIGN_CHECK_EN
        .oIFID_AdEL      (oIFID_AdEL),
`endif
        ._oPC            (_oPC),
        ._oPCNext        (_oPCNext)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcaf;
        logic        adel;
    } item_t;
    item_t sb[$];

    // Reference model: one outstanding request (possibly doomed) or one parked word.
    logic [31:0] m_pc, m_ra, m_held, m_inst, m_pcaf;
    logic        m_req_on, m_doomed, m_valid, m_adel;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == RST_PC) return 32'h20080005;
        return (a * 32'h9e3779b1) ^ 32'h13579bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ra = RST_PC; m_held = '0;
        m_inst = NOP; m_pcaf = '0; m_valid = 1'b0;
        m_req_on = 1'b1; m_doomed = 1'b0; m_adel = 1'b0;
        sb.delete();
    endtask

    task automatic model_update(input logic s, input logic f, input logic r, input logic [31:0] rt,
                                input logic pl, input logic [31:0] pld, input logic ack);
        logic        redir, tmis, cap, cadel;
        logic [31:0] tgt, cword, cpcaf;
        redir = pl | r;
        tgt   = pl ? pld : rt;
        tmis  = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        tmis = |tgt[1:0];
        tgt  = {tgt[31:2], 2'b00};
`endif
        cap = 1'b0; cword = '0; cpcaf = m_pc + 32'd4; cadel = m_adel;
        if (!m_req_on) begin
            if (redir) begin
                m_pc = tgt; m_ra = tgt; m_req_on = 1'b1; m_adel = tmis;
            end else if (!s) begin
                cap = 1'b1; cword = m_held; m_pc = m_pc + 32'd4; m_ra = m_pc; m_req_on = 1'b1; m_adel = 1'b0;
            end
        end else if (m_doomed) begin
            if (redir) begin m_pc = tgt; m_adel = tmis; end
            if (ack) begin m_doomed = 1'b0; m_ra = m_pc; end
        end else if (!ack) begin
            if (redir) begin m_pc = tgt; m_adel = tmis; m_doomed = 1'b1; end
        end else if (redir) begin
            m_pc = tgt; m_ra = tgt; m_adel = tmis;
        end else if (!s) begin
            cap = 1'b1; cword = mem(m_ra); m_pc = m_pc + 32'd4; m_ra = m_pc; m_adel = 1'b0;
        end else begin
            m_held = mem(m_ra); m_req_on = 1'b0;
        end
        if (f || (!cap && !s)) begin
            m_inst = NOP; m_valid = 1'b0;
        end else if (cap) begin
            m_inst = cword; m_pcaf = cpcaf; m_valid = 1'b1;
        end
        if (cap && !f) sb.push_back('{cword, cpcaf, cadel});
    endtask

    task automatic check_state();
        chk("inst_req", {31'd0, oInstReq}, {31'd0, m_req_on});
        if (m_req_on) chk("req_addr", oRdInstAddr, m_ra);
        chk("pc", _oPC, m_pc);
        chk("ifid_valid", {31'd0, oIFID_Valid}, {31'd0, m_valid});
        chk("ifid_inst", oIFID_Inst, m_inst);
        chk("ifid_pcaf", oIFID_PCAddFour, m_pcaf);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic s, input logic f, input logic r, input logic [31:0] rt,
                        input logic pl, input logic [31:0] pld, input logic want_ack);
        check_state();
        iStall = s; iFlush = f; iRedirect = r; iRedirectPC = rt; _iPCLoad = pl; _iPCLoadData = pld;
        iInstAck = want_ack & oInstReq;
        iRdInst  = iInstAck ? mem(oRdInstAddr) : $urandom;
        model_update(s, f, r, rt, pl, pld, iInstAck);
        #1;
        chk("pc_next", _oPCNext, m_pc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        iRst_n = 1'b0;
        iStall = 0; iFlush = 0; iRedirect = 0; _iPCLoad = 0; iInstAck = 0;
        #2;
        chk("rst_valid", {31'd0, oIFID_Valid}, 32'd0);
        chk("rst_inst", oIFID_Inst, NOP);
        chk("rst_pcaf", oIFID_PCAddFour, 32'd0);
        chk("rst_pc", _oPC, RST_PC);
        chk("rst_addr", oRdInstAddr, RST_PC);
`ifdef IF_ALIGN_CHECK_EN
        chk("rst_adel", {31'd0, oIFID_AdEL}, 32'd0);
`endif
        @(negedge clk);
        iRst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: a valid IF/ID not held by last cycle's stall is a fresh capture.
    initial begin
        logic  ps;
        item_t it, last;
        last = '{NOP, 32'd0, 1'b0};
        forever begin
            @(posedge clk);
            ps = iStall;
            @(negedge clk);
            if (iRst_n && oIFID_Valid) begin
                if (!ps) begin
                    if (sb.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_empty: got inst %h with no expected capture", oIFID_Inst);
                    end else begin
                        it = sb.pop_front();
                        chk("sb_inst", oIFID_Inst, it.inst);
                        chk("sb_pcaf", oIFID_PCAddFour, it.pcaf);
`ifdef IF_ALIGN_CHECK_EN
                        chk("sb_adel", {31'd0, oIFID_AdEL}, {31'd0, it.adel});
`endif
                        last = it;
                    end
                end else begin
                    chk("hold_inst", oIFID_Inst, last.inst);
                    chk("hold_pcaf", oIFID_PCAddFour, last.pcaf);
                end
            end
        end
    end

    initial begin
        logic        s, f, r, pl;
        logic [31:0] rt, pld;
        @(negedge clk);
        do_reset();
        // Single-cycle ack straight out of reset
        chk("t1_addr", oRdInstAddr, RST_PC);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t1_inst", oIFID_Inst, 32'h20080005);
        chk("t1_pcaf", oIFID_PCAddFour, 32'h004000ac);
        chk("t1_pc", _oPC, 32'h004000ac);
        // Ack under stall parks the word
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t2_req", {31'd0, oInstReq}, 32'd0);
        chk("t2_inst", oIFID_Inst, 32'h20080005);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t2_pc", _oPC, 32'h004000b0);
        chk("t2_inst2", oIFID_Inst, mem(32'h004000ac));
        // Redirect with request in flight
        step(0, 0, 1, 32'h00400200, 0, 0, 0);
        chk("t3_addr_old", oRdInstAddr, 32'h004000b0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t3_valid", {31'd0, oIFID_Valid}, 32'd0);
        chk("t3_addr_new", oRdInstAddr, 32'h00400200);
        // Redirect together with ack
        step(0, 0, 1, 32'h00400300, 0, 0, 1);
        chk("t4_addr", oRdInstAddr, 32'h00400300);
        // Flush beats stall and capture; PC load beats redirect
        step(1, 1, 0, 0, 0, 0, 1);
        chk("t5_valid", {31'd0, oIFID_Valid}, 32'd0);
        chk("t5_req", {31'd0, oInstReq}, 32'd0);
        step(0, 0, 1, 32'h00400500, 1, 32'h00400400, 0);
        chk("t5_pc", _oPC, 32'h00400400);
        // PC wrap
        step(0, 0, 0, 0, 1, 32'hfffffffc, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t6_pc", _oPC, 32'h00000000);
        chk("t6_pcaf", oIFID_PCAddFour, 32'h00000000);
        // Misaligned redirect target
        step(0, 0, 1, 32'h00400202, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
`ifdef IF_ALIGN_CHECK_EN
        chk("t6_addr_al", oRdInstAddr, 32'h00400200);
`else
        chk("t6_addr_raw", oRdInstAddr, 32'h00400202);
`endif
        step(0, 0, 0, 0, 0, 0, 1);
`ifdef IF_ALIGN_CHECK_EN
        chk("t6_adel", {31'd0, oIFID_AdEL}, 32'd1);
`endif
        // Randomised traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            s   = ($urandom % 4) == 0;
            f   = ($urandom % 10) == 0;
            r   = ($urandom % 12) == 0;
            pl  = ($urandom % 25) == 0;
            rt  = ($urandom & 32'h00fffffc) | ((($urandom % 8) == 0) ? ($urandom % 4) : 0);
            pld = $urandom & 32'h00fffffc;
            step(s, f, r, rt, pl, pld, $urandom % 2);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
